// File: rtl/mem_port_arb.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arb
// Purpose  : Shares one memory port between an instruction-fetch requester
//            and a data (load/store) requester, with starvation control and
//            an access timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arb #(
  parameter int TMO = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err
);

  localparam int CW = (TMO < 2) ? 1 : $clog2(TMO + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    streak_q, streak_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          own_d_q, own_d_d;   // 1: current/last grant belongs to data port
  logic          err_q, err_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      streak_q   <= '0;
      cnt_q      <= '0;
      own_d_q    <= 1'b0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      streak_q   <= streak_d;
      cnt_q      <= cnt_d;
      own_d_q    <= own_d_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Arbitration, grant sequencing, completion capture and timeout.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    streak_d   = streak_q;
    cnt_d      = cnt_q;
    own_d_d    = own_d_q;
    err_d      = err_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        err_d = 1'b0;
        // Data has priority unless fetch has already been passed over twice.
        if (d_req && !(if_req && (streak_q == 2'd2))) begin
          state_d = GNT_D;
          addr_d  = d_addr;
          we_d    = d_we;
          wdata_d = d_wdata;
          own_d_d = 1'b1;
          if (if_req && (streak_q != 2'd2)) begin
            streak_d = streak_q + 2'd1;
          end
        end else if (if_req) begin
          state_d  = GNT_I;
          addr_d   = if_addr;
          we_d     = 1'b0;
          wdata_d  = '0;
          own_d_d  = 1'b0;
          streak_d = '0;
        end
      end
      GNT_I, GNT_D: begin
        if (mem_ack) begin
          state_d = DONE;
          if (own_d_q) d_rdata_d  = mem_rdata;
          else         if_rdata_d = mem_rdata;
        end else if (cnt_q == CW'(TMO - 1)) begin
          // Last permitted cycle passed with no ack: complete with error.
          state_d = DONE;
          err_d   = 1'b1;
          if (own_d_q) d_rdata_d  = '0;
          else         if_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from state so reset clears them immediately.
  always_comb begin
    mem_en    = (state_q == GNT_I) || (state_q == GNT_D);
    mem_we    = mem_en && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_done   = (state_q == DONE) && !own_d_q;
    d_done    = (state_q == DONE) && own_d_q;
    err       = (state_q == DONE) && err_q;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arb
// Purpose  : Randomised scoreboard bench for mem_port_arb plus directed
//            store / reset-mid-access / fetch-latency sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arb;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        err;

  mem_port_arb #(.TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    bit          err;
  } exp_t;
  exp_t exp_q[$];

  // Reference state: starvation count and the values each port should hold.
  int          m_streak = 0;
  logic [31:0] m_if_rdata = '0;
  logic [31:0] m_d_rdata  = '0;

  bit directed = 1'b0;
  logic        mdl_ack = 1'b0, dir_ack = 1'b0;
  logic [31:0] mdl_rdata = '0, dir_rdata = '0;
  assign mem_ack   = directed ? dir_ack   : mdl_ack;
  assign mem_rdata = directed ? dir_rdata : mdl_rdata;

  // Request levels as seen at the most recent rising edge.
  logic snap_if = 1'b0, snap_d = 1'b0;
  always @(posedge clk) begin
    snap_if <= if_req;
    snap_d  <= d_req;
  end

  // Memory model: predicts each grant, checks the memory-side request and
  // chooses the response (ack after 1..4 cycles, or silence for a timeout).
  initial begin
    bit          prev_en = 1'b0;
    bit          is_d, tmo_mode;
    int          lat = 1, en_len = 0;
    logic [31:0] rd;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!directed) begin
        if (mem_en && !prev_en) begin
          if (!snap_d && !snap_if) chk("grant_without_request", 32'd1, 32'd0);
          is_d = snap_d && !(snap_if && m_streak == 2);
          if (is_d) begin
            if (snap_if) m_streak = (m_streak < 2) ? m_streak + 1 : 2;
            chk("gnt_d_addr", 32'(mem_addr), 32'(d_addr));
            chk("gnt_d_we", 32'(mem_we), 32'(d_we));
            if (d_we) chk("gnt_d_wdata", mem_wdata, d_wdata);
          end else begin
            m_streak = 0;
            chk("gnt_i_addr", 32'(mem_addr), 32'(if_addr));
            chk("gnt_i_we", 32'(mem_we), 32'd0);
          end
          tmo_mode = ($urandom_range(0, 7) == 0);
          lat      = $urandom_range(1, 4);
          rd       = $urandom;
          en_len   = 0;
          e.is_d   = is_d;
          e.rdata  = tmo_mode ? 32'h0 : rd;
          e.err    = tmo_mode;
          exp_q.push_back(e);
        end
        if (mem_en) begin
          en_len++;
          if (!tmo_mode && en_len == lat) begin
            mdl_ack   = 1'b1;
            mdl_rdata = rd;
          end else begin
            mdl_ack   = 1'b0;
            mdl_rdata = $urandom;
          end
        end else begin
          if (prev_en) chk("mem_en_length", 32'(en_len), tmo_mode ? 32'(TMO) : 32'(lat));
          // Stray acks while nothing is granted must be ignored.
          mdl_ack   = ($urandom_range(0, 3) == 0);
          mdl_rdata = $urandom;
        end
      end
      prev_en = mem_en;
    end
  end

  // Monitor: every done pulse is matched against the oldest expected completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!directed) begin
        if (if_done && d_done) chk("both_done", 32'd1, 32'd0);
        if (if_done || d_done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("done_port", 32'(d_done), 32'(e.is_d));
            chk("done_err", 32'(err), 32'(e.err));
            if (e.is_d) begin
              m_d_rdata = e.rdata;
            end else begin
              m_if_rdata = e.rdata;
            end
            chk("d_rdata", d_rdata, m_d_rdata);
            chk("if_rdata", if_rdata, m_if_rdata);
          end
        end else if (err) begin
          chk("err_without_done", 32'd1, 32'd0);
        end
      end
    end
  end

  task automatic run_fetch(input int n);
    int cnt;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      if_addr = {1'b0, 15'($urandom)};
      if_req  = 1'b1;
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!if_done && cnt < 200);
      if (!if_done) chk("if_done_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      if_req = 1'b0;
    end
  endtask

  task automatic run_data(input int n);
    int cnt;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 1)) @(posedge clk);
      #1;
      d_addr  = {1'b1, 15'($urandom)};
      d_we    = 1'($urandom);
      d_wdata = $urandom;
      d_req   = 1'b1;
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!d_done && cnt < 200);
      if (!d_done) chk("d_done_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      d_req = 1'b0;
    end
  endtask

  initial begin
    int  cnt;
    bit  saw_dd;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", {27'd0, mem_en, mem_we, if_done, d_done, err}, 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    rst = 1'b0;

    fork
      run_fetch(50);
      run_data(80);
    join
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 100) begin @(negedge clk); cnt++; end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    directed = 1'b1;

    // Store, then reset while it is granted.
    d_we = 1'b1; d_addr = 16'h0044; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!mem_en && cnt < 20);
    chk("st_mem_en", 32'(mem_en), 32'd1);
    chk("st_mem_we", 32'(mem_we), 32'd1);
    chk("st_mem_addr", 32'(mem_addr), 32'h0044);
    chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_ctrl", {27'd0, mem_en, mem_we, if_done, d_done, err}, 32'd0);
    chk("midrst_addr", 32'(mem_addr), 32'd0);
    chk("midrst_wdata", mem_wdata, 32'd0);
    chk("midrst_rdata", if_rdata | d_rdata, 32'd0);
    d_req = 1'b0; if_req = 1'b1; if_addr = 16'h0010;
    @(posedge clk); #1;
    rst = 1'b0;

    // Fetch after release: ack in the second granted cycle.
    saw_dd = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk); cnt++;
      if (d_done) saw_dd = 1'b1;
    end while (!mem_en && cnt < 20);
    chk("post_rst_no_d_done", 32'(saw_dd), 32'd0);
    chk("f_mem_addr", 32'(mem_addr), 32'h0010);
    chk("f_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("f_mem_en_cycle2", 32'(mem_en), 32'd1);
    dir_ack = 1'b1; dir_rdata = 32'h8123_4567;
    @(negedge clk);
    dir_ack = 1'b0;
    chk("f_mem_en_dropped", 32'(mem_en), 32'd0);
    chk("f_done", {30'd0, if_done, d_done}, 32'd2);
    chk("f_err", 32'(err), 32'd0);
    chk("f_rdata", if_rdata, 32'h8123_4567);
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    chk("f_done_one_pulse", 32'(if_done), 32'd0);
    chk("f_rdata_held", if_rdata, 32'h8123_4567);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: if_req  in  1  instruction-fetch request; held until if_done.
REQ-004 SHALL have: if_addr  in  16  fetch word address, stable while if_req.
REQ-005 SHALL have: if_done  out  1  one-cycle pulse, fetch complete.
REQ-006 SHALL have: if_rdata  out  32  fetched word, valid with if_done.
REQ-007 SHALL have: d_req  in  1  data request (LOD/STR); held until d_done.
REQ-008 SHALL have: d_we  in  1  1=store, 0=load.
REQ-009 SHALL have: d_addr  in  16  data word address.
REQ-010 SHALL have: d_wdata  in  32  store data.
REQ-011 SHALL have: d_done  out  1  one-cycle pulse, data access complete.
REQ-012 SHALL have: d_rdata  out  32  load data, valid with d_done.
REQ-013 SHALL have: mem_en  out  1  memory access strobe.
REQ-014 SHALL have: mem_we  out  1  memory write enable.
REQ-015 SHALL have: mem_addr  out  16  memory address.
REQ-016 SHALL have: mem_wdata  out  32  memory write data.
REQ-017 SHALL have: mem_rdata  in  32  memory read data, valid with mem_ack.
REQ-018 SHALL have: mem_ack  in  1  memory completion, one cycle, 1..N cycles after mem_en rises.
REQ-019 SHALL have: err  out  1  one-cycle pulse with done when access timed out.
REQ-020 SHALL have parameter TMO, default 15, meaning max cycles waited for mem_ack.

Function
REQ-021 SHALL implement FSM states IDLE, GNT_I, GNT_D, DONE.
REQ-022 IDLE: with any request pending, SHALL select a winner, latch its addr/we/wdata into mem_* registers, go to GNT_I or GNT_D next edge.
REQ-023 Arbitration: d_req SHALL win over if_req, except if_req SHALL win when streak counter = 2.
REQ-024 Streak counter (2 bits) SHALL increment on each data grant made while if_req=1, clear on any fetch grant, saturate at 2.
REQ-025 GNT_x: mem_en SHALL be 1 and mem_addr/mem_we/mem_wdata SHALL hold latched values; fetch grants drive mem_we=0.
REQ-026 GNT_x: mem_ack=1 SHALL capture mem_rdata into the granted requester's rdata register and go to DONE.
REQ-027 DONE: mem_en=0; granted requester's done SHALL pulse exactly one cycle; next state IDLE.
REQ-028 Latency: request seen in IDLE at edge k, mem_en high from k+1; mem_ack at edge m -> done high cycle m+1; back-to-back grants SHALL be separated by at least one IDLE cycle.
REQ-029 Timeout: cycle counter SHALL count GNT_x cycles; reaching TMO without mem_ack SHALL go to DONE with done and err pulsed, rdata = 32'h0000_0000.
REQ-030 mem_ack outside GNT_x SHALL be ignored.
REQ-031 Requests dropped while granted SHALL NOT abort the access; done still pulses.
REQ-032 rdata registers SHALL hold their value until the next completion for that port.
REQ-033 if_done and d_done SHALL never be high in the same cycle.

Reset
REQ-034 rst=1 SHALL immediately force IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_done=0, d_done=0, err=0, if_rdata=0, d_rdata=0, streak=0, timeout counter=0.
REQ-035 Reset mid-access SHALL abandon it with no done pulse; first grant after release follows REQ-023 with streak=0.

Verification
REQ-036 Fetch only: if_addr=0x0010, mem_ack 2 cycles after mem_en, mem_rdata=0x8123_4567 -> mem_en high 2 cycles, if_done one pulse, if_rdata=0x8123_4567.
REQ-037 Simultaneous if_req and d_req (load 0x0020) -> data granted first, d_done, then fetch granted after one IDLE cycle.
REQ-038 Fetch held, d_req continuously reasserted for 3 accesses -> grant order D, D, I, D.
REQ-039 Store d_addr=0x0044, d_wdata=0xDEAD_BEEF -> mem_we=1, mem_addr=0x0044, mem_wdata=0xDEAD_BEEF during GNT_D; d_done pulses.
REQ-040 No mem_ack for TMO=15 cycles -> mem_en drops, done and err pulse together, rdata=0.
REQ-041 rst asserted during GNT_D -> outputs zero same cycle, no d_done; after release pending if_req granted normally.
